// File: rtl/apb_mst_bridge_if.sv
// Request/acknowledge and APB bus bundle for apb_mst_bridge.
// master: bridge side; slave: request source plus APB slave side.
interface apb_mst_bridge_if #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 32
);
  logic                  req_vld;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  non_sec;
  logic                  ack_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [2:0]            pprot;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    input  req_vld, addr, wr_en, rd_en,
    input  wr_data, non_sec,
    output ack_vld, rd_data, err,
    output psel, penable, pwrite,
    output paddr, pwdata, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    output req_vld, addr, wr_en, rd_en,
    output wr_data, non_sec,
    input  ack_vld, rd_data, err,
    input  psel, penable, pwrite,
    input  paddr, pwdata, pprot,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_mst_bridge.sv
// Register request -> APB master bridge with ACCESS timeout.
// Ports: pclk, presetn (async low), bus (apb_mst_bridge_if.master).
module apb_mst_bridge #(
  parameter int ADDR_WIDTH   = 48,
  parameter int DATA_WIDTH   = 32,
  parameter int TMOUT_CYCLES = 256
) (
  input  logic               pclk,
  input  logic               presetn,
  apb_mst_bridge_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ACK
  } state_t;

  localparam bit TM_EN = (TMOUT_CYCLES != 0);
  localparam logic [15:0] TM_LAST =
    TM_EN ? 16'(TMOUT_CYCLES - 1) : 16'd0;
  localparam logic [DATA_WIDTH-1:0] ABORT_DATA =
    DATA_WIDTH'(32'hdead_1eaf);

  state_t                state_q;
  logic [15:0]           cnt_q;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  psel_q;
  logic                  pen_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [2:0]            pprot_q;

  logic                  tmo;
  assign tmo = TM_EN && (cnt_q == TM_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pprot_q  <= '0;
    end else begin
      // ack and its payload are single-cycle pulses
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_vld) begin
            if (bus.wr_en || bus.rd_en) begin
              psel_q   <= 1'b1;
              pwrite_q <= bus.wr_en;
              paddr_q  <= bus.addr;
              pwdata_q <= bus.wr_data;
              pprot_q  <= {1'b0, bus.non_sec, 1'b0};
              state_q  <= S_SETUP;
            end else begin
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_ACK;
            end
          end
        end
        S_SETUP: begin
          pen_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (bus.pready || tmo) begin
            // pready wins over a same-cycle timeout
            ack_q <= 1'b1;
            if (bus.pready) begin
              rdata_q <= pwrite_q ? '0 : bus.prdata;
              err_q   <= bus.pslverr;
            end else begin
              rdata_q <= ABORT_DATA;
              err_q   <= 1'b1;
            end
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pprot_q  <= '0;
            state_q  <= S_ACK;
          end else if (cnt_q != 16'hffff) begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_vld = ack_q;
  assign bus.rd_data = rdata_q;
  assign bus.err     = err_q;
  assign bus.psel    = psel_q;
  assign bus.penable = pen_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.pprot   = pprot_q;

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Scoreboard bench for apb_mst_bridge.
// Directed requests, queue-based ack and APB checking.
module tb_apb_mst_bridge;

  localparam int AW  = 48;
  localparam int DW  = 32;
  localparam int TMO = 4;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rd;
    logic        err;
  } ack_t;

  typedef struct {
    logic [47:0] addr;
    logic [31:0] wd;
    logic        wr;
    logic [2:0]  prot;
  } apb_t;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_mst_bridge_if #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) bus ();

  apb_mst_bridge #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TMOUT_CYCLES(TMO)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;

  ack_t exp_ack[$];
  apb_t exp_apb[$];
  apb_t cur;

  int          slv_wait = 0;
  bit          slv_never = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  logic        force_pready = 1'b0;
  int          acc_cnt = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(posedge pclk)
    acc_cnt <= (bus.psel && bus.penable) ? acc_cnt + 1 : 0;

  always_comb begin
    bus.pready = force_pready |
      (bus.psel && bus.penable && !slv_never &&
       acc_cnt == slv_wait);
  end
  assign bus.prdata  = slv_rdata;
  assign bus.pslverr = slv_err;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  // ack monitor
  always @(negedge pclk) begin
    ack_t e;
    if (presetn) begin
      if (bus.ack_vld) begin
        if (exp_ack.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_ack: ack_vld=1 at %0d, required 0",
                   cyc);
        end else begin
          e = exp_ack.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(e.cyc));
          chk("ack_rd_data", 64'(bus.rd_data), 64'(e.rd));
          chk("ack_err", 64'(bus.err), 64'(e.err));
        end
      end else begin
        chk("idle_rd_data", 64'(bus.rd_data), 64'd0);
        chk("idle_err", 64'(bus.err), 64'd0);
      end
    end
  end

  // APB monitor
  always @(negedge pclk) begin
    if (presetn) begin
      if (bus.psel && !bus.penable) begin
        if (exp_apb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_xfer: psel=1 at %0d, required 0",
                   cyc);
        end else begin
          cur = exp_apb.pop_front();
          chk("setup_paddr", 64'(bus.paddr), 64'(cur.addr));
          chk("setup_pwdata", 64'(bus.pwdata), 64'(cur.wd));
          chk("setup_pwrite", 64'(bus.pwrite), 64'(cur.wr));
          chk("setup_pprot", 64'(bus.pprot), 64'(cur.prot));
        end
      end else if (bus.psel) begin
        chk("acc_paddr", 64'(bus.paddr), 64'(cur.addr));
        chk("acc_pwdata", 64'(bus.pwdata), 64'(cur.wd));
        chk("acc_pwrite", 64'(bus.pwrite), 64'(cur.wr));
        chk("acc_pprot", 64'(bus.pprot), 64'(cur.prot));
      end else begin
        chk("nosel_penable", 64'(bus.penable), 64'd0);
        chk("nosel_paddr", 64'(bus.paddr), 64'd0);
        chk("nosel_pwdata", 64'(bus.pwdata), 64'd0);
        chk("nosel_pwrite", 64'(bus.pwrite), 64'd0);
        chk("nosel_pprot", 64'(bus.pprot), 64'd0);
      end
    end
  end

  task automatic issue(logic wr, logic rd, logic [47:0] a,
                       logic [31:0] d, logic ns);
    @(posedge pclk);
    #1;
    bus.req_vld = 1'b1;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.addr    = a;
    bus.wr_data = d;
    bus.non_sec = ns;
    t0 = cyc;
    @(posedge pclk);
    #1;
    bus.req_vld = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    bus.non_sec = 1'b0;
  endtask

  task automatic push_ack(int off, logic [31:0] rd, logic e);
    ack_t a;
    a.cyc = t0 + off;
    a.rd  = rd;
    a.err = e;
    exp_ack.push_back(a);
  endtask

  task automatic push_apb(logic [47:0] a, logic [31:0] d,
                          logic wr, logic [2:0] p);
    apb_t x;
    x.addr = a;
    x.wd   = d;
    x.wr   = wr;
    x.prot = p;
    exp_apb.push_back(x);
  endtask

  task automatic at(int n);
    do @(negedge pclk);
    while (cyc < t0 + n);
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_ack.size() != 0 && k < 40) begin
      @(negedge pclk);
      k++;
    end
    chk("ack_seen", 64'(exp_ack.size()), 64'd0);
    exp_ack.delete();
    repeat (3) @(negedge pclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_vld = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    bus.non_sec = 1'b0;
    repeat (3) @(negedge pclk);

    chk("rst_psel", 64'(bus.psel), 64'd0);
    chk("rst_penable", 64'(bus.penable), 64'd0);
    chk("rst_ack", 64'(bus.ack_vld), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_pwrite", 64'(bus.pwrite), 64'd0);
    chk("rst_pprot", 64'(bus.pprot), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);

    // zero-wait write
    slv_wait = 0;
    push_apb(48'h1000, 32'hA5A5_0001, 1'b1, 3'b000);
    issue(1'b1, 1'b0, 48'h1000, 32'hA5A5_0001, 1'b0);
    push_ack(3, 32'h0, 1'b0);
    at(1);
    chk("w_c1_psel", 64'(bus.psel), 64'd1);
    chk("w_c1_penable", 64'(bus.penable), 64'd0);
    at(2);
    chk("w_c2_penable", 64'(bus.penable), 64'd1);
    wait_done();

    // read, 3 wait states, non_sec, pslverr
    slv_wait  = 3;
    slv_rdata = 32'h1234_5678;
    slv_err   = 1'b1;
    push_apb(48'h2000, 32'h0, 1'b0, 3'b010);
    issue(1'b0, 1'b1, 48'h2000, 32'h0, 1'b1);
    push_ack(6, 32'h1234_5678, 1'b1);
    at(5);
    chk("r3_c5_penable", 64'(bus.penable), 64'd1);
    chk("r3_c5_pprot", 64'(bus.pprot), 64'd2);
    wait_done();

    // timeout, then late pready
    slv_never = 1'b1;
    slv_err   = 1'b0;
    push_apb(48'h3000, 32'h0, 1'b0, 3'b000);
    issue(1'b0, 1'b1, 48'h3000, 32'h0, 1'b0);
    push_ack(6, 32'hdead_1eaf, 1'b1);
    at(2);
    chk("to_c2_penable", 64'(bus.penable), 64'd1);
    at(5);
    chk("to_c5_penable", 64'(bus.penable), 64'd1);
    at(6);
    chk("to_c6_psel", 64'(bus.psel), 64'd0);
    @(posedge pclk);
    #1;
    force_pready = 1'b1;
    @(posedge pclk);
    #1;
    force_pready = 1'b0;
    slv_never = 1'b0;
    wait_done();

    // pready in final timeout cycle
    slv_wait  = 3;
    slv_rdata = 32'h55;
    slv_err   = 1'b0;
    push_apb(48'h3100, 32'h0, 1'b0, 3'b000);
    issue(1'b0, 1'b1, 48'h3100, 32'h0, 1'b0);
    push_ack(6, 32'h55, 1'b0);
    wait_done();

    // illegal request
    issue(1'b0, 1'b0, 48'h4000, 32'h0, 1'b0);
    push_ack(1, 32'h0, 1'b1);
    at(1);
    chk("ill_c1_psel", 64'(bus.psel), 64'd0);
    wait_done();

    // write with wait and pslverr: rd_data stays 0
    slv_wait  = 1;
    slv_rdata = 32'hFFFF_FFFF;
    slv_err   = 1'b1;
    push_apb(48'h4400, 32'h0BB0_0BB0, 1'b1, 3'b010);
    issue(1'b1, 1'b0, 48'h4400, 32'h0BB0_0BB0, 1'b1);
    push_ack(4, 32'h0, 1'b1);
    wait_done();

    // second req_vld during ACCESS is dropped
    slv_wait  = 2;
    slv_rdata = 32'hCAFE_0001;
    slv_err   = 1'b0;
    push_apb(48'h5000, 32'h0, 1'b0, 3'b000);
    issue(1'b0, 1'b1, 48'h5000, 32'h0, 1'b0);
    push_ack(5, 32'hCAFE_0001, 1'b0);
    @(posedge pclk);
    #1;
    bus.req_vld = 1'b1;
    bus.wr_en   = 1'b1;
    bus.addr    = 48'h6000;
    bus.wr_data = 32'h1111_2222;
    @(posedge pclk);
    #1;
    bus.req_vld = 1'b0;
    bus.wr_en   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    wait_done();
    repeat (6) @(negedge pclk);

    // async reset in ACCESS
    slv_never = 1'b1;
    push_apb(48'h7000, 32'h0, 1'b0, 3'b000);
    issue(1'b0, 1'b1, 48'h7000, 32'h0, 1'b0);
    at(3);
    presetn = 1'b0;
    #1;
    chk("rst_mid_psel", 64'(bus.psel), 64'd0);
    chk("rst_mid_penable", 64'(bus.penable), 64'd0);
    chk("rst_mid_ack", 64'(bus.ack_vld), 64'd0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    slv_never = 1'b0;
    repeat (2) @(negedge pclk);
    slv_wait  = 1;
    slv_rdata = 32'h0BAD_F00D;
    slv_err   = 1'b0;
    push_apb(48'h8000, 32'h0, 1'b0, 3'b000);
    issue(1'b0, 1'b1, 48'h8000, 32'h0, 1'b0);
    push_ack(4, 32'h0BAD_F00D, 1'b0);
    wait_done();

    chk("apb_all_seen", 64'(exp_apb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
